// File: rtl/ternary_dot_pkg.sv
// Shared types, default widths and the product helper for the ternary dot-product sequencer.
package ternary_dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_N_TAPS = 8;
    localparam int DEF_DATA_W = 9;
    localparam int DEF_COEF_W = 2;
    localparam int DEF_ACC_W  = 16;

    // Width at which operands are sign-extended before multiplying; ACC_W must stay below it.
    localparam int PROD_W = 32;

    // Signed product of two operands already sign-extended to PROD_W bits.
    function automatic logic signed [PROD_W-1:0] sext_prod(
        input logic signed [PROD_W-1:0] x,
        input logic signed [PROD_W-1:0] c
    );
        return x * c;
    endfunction

endpackage

// File: rtl/dot_mac_unit.sv
// Combinational multiply-accumulate: sum = acc + x*c, wrapping modulo 2^ACC_W.
module dot_mac_unit
    import ternary_dot_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [COEF_W-1:0] c_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [PROD_W-1:0]       x_ext;
    logic signed [PROD_W-1:0]       c_ext;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        prod_lo;
    logic [PROD_W-ACC_W-1:0]        prod_hi_unused;

    // Sign-extend both operands, multiply, and keep only the accumulator-width low bits.
    always_comb begin
        x_ext          = PROD_W'(x_i);
        c_ext          = PROD_W'(c_i);
        prod           = sext_prod(x_ext, c_ext);
        prod_lo        = prod[ACC_W-1:0];
        prod_hi_unused = prod[PROD_W-1:ACC_W];
        sum_o          = acc_i + prod_lo;
    end

endmodule

// File: rtl/ternary_dot_seq.sv
// Frame sequencer: pairs each accepted sample with its coefficient, accumulates one MAC
// pass per sample and presents the frame's dot product on a valid/ready result port.
module ternary_dot_seq
    import ternary_dot_pkg::*;
#(
    parameter int N_TAPS = DEF_N_TAPS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        cfg_we_i,
    input  logic [$clog2(N_TAPS)-1:0]   cfg_addr_i,
    input  logic signed [COEF_W-1:0]    cfg_data_i,
    input  logic                        clr_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic signed [DATA_W-1:0]    in_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [ACC_W-1:0]     out_data_o,
    output logic                        busy_o
);

    localparam int IDX_W = $clog2(N_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam bit ADDR_FULL = (N_TAPS == (1 << IDX_W));

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           tap_idx_q, tap_idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0]    out_data_q, out_data_d;
    logic signed [COEF_W-1:0]   coef_q [N_TAPS];

    logic signed [COEF_W-1:0]   coef_sel;
    logic signed [ACC_W-1:0]    mac_acc;
    logic signed [ACC_W-1:0]    mac_sum;
    logic                       accept;
    logic                       addr_ok;
    logic                       coef_we;

    // Handshake and datapath operand selection; a new frame always starts from a zero accumulator.
    always_comb begin
        in_ready_o  = (state_q == IDLE) || (state_q == ACCUM);
        busy_o      = (state_q != IDLE);
        out_valid_o = out_valid_q;
        out_data_o  = out_data_q;
        accept      = in_valid_i && in_ready_o && !clr_i;
        coef_sel    = coef_q[tap_idx_q];
        mac_acc     = (state_q == IDLE) ? '0 : acc_q;
        addr_ok     = ADDR_FULL || (32'(cfg_addr_i) < N_TAPS);
        coef_we     = cfg_we_i && (state_q == IDLE) && !clr_i && addr_ok;
    end

    dot_mac_unit #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_mac (
        .acc_i (mac_acc),
        .x_i   (in_data_i),
        .c_i   (coef_sel),
        .sum_o (mac_sum)
    );

    // Next-state logic: clr overrides everything, otherwise walk IDLE -> ACCUM -> DONE -> IDLE.
    always_comb begin
        state_d     = state_q;
        tap_idx_d   = tap_idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (clr_i) begin
            state_d     = IDLE;
            tap_idx_d   = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d     = mac_sum;
                        tap_idx_d = ONE_IDX;
                        state_d   = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = mac_sum;
                        if (tap_idx_q == LAST_IDX) begin
                            tap_idx_d   = '0;
                            state_d     = DONE;
                            out_valid_d = 1'b1;
                            out_data_d  = mac_sum;
                        end else begin
                            tap_idx_d = tap_idx_q + ONE_IDX;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        acc_d       = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    tap_idx_d   = '0;
                    acc_d       = '0;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                end
            endcase
        end
    end

    // State, tap counter, accumulator and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            tap_idx_q   <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tap_idx_q   <= tap_idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Coefficient table: writable only while idle, cleared by reset but kept across clr.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_we) begin
            coef_q[cfg_addr_i] <= cfg_data_i;
        end
    end

endmodule

// File: tb/tb_ternary_dot_seq.sv
// Self-checking bench for ternary_dot_seq: a 16-bit and a 12-bit accumulator build share
// the same stimulus; expected dot products are queued as frames complete and popped on output.
module tb_ternary_dot_seq;

    localparam int N = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic signed [1:0]  cfg_data;
    logic               clr;
    logic               in_valid;
    logic signed [8:0]  in_data;
    logic               out_ready;

    logic               in_ready16, out_valid16, busy16;
    logic signed [15:0] out_data16;
    logic               in_ready12, out_valid12, busy12;
    logic signed [11:0] out_data12;

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_q[$];
    int model_coef[N];
    int model_acc;
    int model_idx;

    always #5 clk = ~clk;

    ternary_dot_seq #(.N_TAPS(N), .DATA_W(9), .COEF_W(2), .ACC_W(16)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready16),
        .in_data_i(in_data), .out_valid_o(out_valid16), .out_ready_i(out_ready),
        .out_data_o(out_data16), .busy_o(busy16)
    );

    ternary_dot_seq #(.N_TAPS(N), .DATA_W(9), .COEF_W(2), .ACC_W(12)) dut12 (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready12),
        .in_data_i(in_data), .out_valid_o(out_valid12), .out_ready_i(out_ready),
        .out_data_o(out_data12), .busy_o(busy12)
    );

    function automatic int wrap16(input int v);
        int t;
        t = v <<< 16;
        return t >>> 16;
    endfunction

    function automatic int wrap12(input int v);
        int t;
        t = v <<< 20;
        return t >>> 20;
    endfunction

    // Reference model: one accepted sample.
    task automatic model_accept(input int x);
        model_acc = model_acc + x * model_coef[model_idx];
        if (model_idx == N - 1) begin
            exp_q.push_back(model_acc);
            model_acc = 0;
            model_idx = 0;
        end else begin
            model_idx++;
        end
    endtask

    task automatic model_abort();
        model_acc = 0;
        model_idx = 0;
    endtask

    // Present one sample and hold it until the handshake edge.
    task automatic drive_sample(input int x);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = 9'(x);
        while (!in_ready16 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready16) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL sample_accept_timeout: in_ready=%0b, required 1", in_ready16);
        end else begin
            @(posedge clk);
            model_accept(x);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val, input bit taken);
        cfg_we   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = 2'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (taken) model_coef[addr] = val;
    endtask

    task automatic idle_gap(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_compared++;
        if (out_valid16 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid16); end
        n_compared++;
        if (busy16 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %0b, required 0", busy16); end
        n_compared++;
        if (in_ready16 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready16); end
        n_compared++;
        if (out_data16 !== 16'sd0) begin n_mismatched++; $display("[TB] FAIL reset_out_data: got %0d, required 0", out_data16); end

        for (int i = 0; i < N; i++) write_coef(i, 1, 1'b1);
        for (int i = 0; i < 3; i++) drive_sample(20 + i);
        n_compared++;
        if (busy16 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midframe_busy: got %0b, required 1", busy16); end

        #2 rst_n = 1'b0;
        #1;
        model_abort();
        for (int i = 0; i < N; i++) model_coef[i] = 0;
        n_compared++;
        if (busy16 !== 1'b0 || busy12 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_reset_busy: got %0b/%0b, required 0/0", busy16, busy12); end
        n_compared++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_reset_handshake: in_ready=%0b out_valid=%0b, required 1/0", in_ready16, out_valid16); end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Coefficients were cleared by reset, so this frame must sum to zero.
        for (int i = 0; i < N; i++) drive_sample(10 + i);
        begin
            int guard = 0;
            int e;
            while (!out_valid16 && guard < 40) begin @(posedge clk); #1; guard++; end
            n_compared++;
            if (!out_valid16 || exp_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_frame_valid: out_valid=%0b queued=%0d, required 1 with a queued result", out_valid16, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                n_compared++;
                if (int'(out_data16) !== wrap16(e)) begin n_mismatched++; $display("[TB] FAIL reset_frame_data: got %0d, required %0d", out_data16, wrap16(e)); end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_basic_frame();
        int e;
        for (int i = 0; i < N; i++) write_coef(i, (i % 2 == 0) ? 1 : -1, 1'b1);
        for (int i = 1; i <= N; i++) drive_sample(i);
        // Result must be visible the cycle after the last accept.
        n_compared++;
        if (out_valid16 !== 1'b1 || out_valid12 !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL basic_latency: out_valid=%0b/%0b, required 1/1", out_valid16, out_valid12);
        end
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_queue: queued=0, required 1");
            e = 0;
        end else begin
            e = exp_q.pop_front();
        end
        for (int k = 0; k < 3; k++) begin
            n_compared++;
            if (int'(out_data16) !== wrap16(e) || out_valid16 !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL basic_hold: out_valid=%0b out_data=%0d, required 1/%0d", out_valid16, out_data16, wrap16(e));
            end
            n_compared++;
            if (int'(out_data12) !== wrap12(e)) begin
                n_mismatched++;
                $display("[TB] FAIL basic_hold12: got %0d, required %0d", out_data12, wrap12(e));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_compared++;
        if (out_valid16 !== 1'b0 || busy16 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_release: out_valid=%0b busy=%0b, required 0/0", out_valid16, busy16);
        end
    endtask

    task automatic test_extremes();
        int samp [2] = '{-256, 255};
        int cval [2] = '{-2, 1};
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) write_coef(i, cval[f], 1'b1);
            for (int i = 0; i < N; i++) drive_sample(samp[f]);
            begin
                int guard = 0;
                int e;
                while (!out_valid16 && guard < 40) begin @(posedge clk); #1; guard++; end
                n_compared++;
                if (!out_valid16 || exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL extreme_valid: out_valid=%0b queued=%0d, required 1 with a queued result", out_valid16, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    n_compared++;
                    if (int'(out_data16) !== wrap16(e)) begin n_mismatched++; $display("[TB] FAIL extreme_data16: got %0d, required %0d", out_data16, wrap16(e)); end
                    n_compared++;
                    if (int'(out_data12) !== wrap12(e)) begin n_mismatched++; $display("[TB] FAIL extreme_wrap12: got %0d, required %0d", out_data12, wrap12(e)); end
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        int next_first;
        for (int i = 0; i < N; i++) write_coef(i, int'($urandom_range(0, 3)) - 2, 1'b1);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) begin
                if (!(f == 1 && i == 0)) begin
                    idle_gap(int'($urandom_range(0, 2)));
                    drive_sample(int'($urandom_range(0, 511)) - 256);
                end else begin
                    drive_sample(next_first);
                end
            end
            // Offer the next frame's first sample while the result is stalled.
            next_first = int'($urandom_range(0, 511)) - 256;
            in_valid = 1'b1;
            in_data  = 9'(next_first);
            begin
                int guard = 0;
                int e;
                while (!out_valid16 && guard < 40) begin @(posedge clk); #1; guard++; end
                n_compared++;
                if (!out_valid16 || exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL bp_valid: out_valid=%0b queued=%0d, required 1 with a queued result", out_valid16, exp_q.size());
                    e = 0;
                end else begin
                    e = exp_q.pop_front();
                end
                for (int k = 0; k < 5; k++) begin
                    n_compared++;
                    if (in_ready16 !== 1'b0 || in_ready12 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_in_ready_done: got %0b/%0b, required 0/0", in_ready16, in_ready12); end
                    n_compared++;
                    if (int'(out_data16) !== wrap16(e) || int'(out_data12) !== wrap12(e)) begin
                        n_mismatched++;
                        $display("[TB] FAIL bp_data: got %0d/%0d, required %0d/%0d", out_data16, out_data12, wrap16(e), wrap12(e));
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
            if (f == 1) in_valid = 1'b0;
        end
        // The offered sample left over after the last frame was never accepted.
        n_compared++;
        if (busy16 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_no_extra_accept: busy=%0b, required 0", busy16); end
    endtask

    task automatic test_config_lockout();
        for (int i = 0; i < N; i++) write_coef(i, 1, 1'b1);
        for (int p = 0; p < 2; p++) begin
            if (p == 1) write_coef(3, -2, 1'b1);
            for (int i = 1; i <= N; i++) begin
                drive_sample(i);
                if (p == 0 && i == 2) write_coef(3, -2, 1'b0);
            end
            begin
                int guard = 0;
                int e;
                while (!out_valid16 && guard < 40) begin @(posedge clk); #1; guard++; end
                if (p == 0) write_coef(3, -1, 1'b0);
                n_compared++;
                if (!out_valid16 || exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL cfg_valid: out_valid=%0b queued=%0d, required 1 with a queued result", out_valid16, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    n_compared++;
                    if (int'(out_data16) !== wrap16(e)) begin n_mismatched++; $display("[TB] FAIL cfg_lockout_frame%0d: got %0d, required %0d", p, out_data16, wrap16(e)); end
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 4; i++) drive_sample(100 + i);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_abort();
        n_compared++;
        if (busy16 !== 1'b0 || out_valid16 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clr_abort: busy=%0b out_valid=%0b, required 0/0", busy16, out_valid16); end

        // clr in IDLE: ready still high but the sample must be dropped.
        in_valid = 1'b1;
        in_data  = 9'sd77;
        clr      = 1'b1;
        n_compared++;
        if (in_ready16 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL clr_idle_ready: got %0b, required 1", in_ready16); end
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        n_compared++;
        if (busy16 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clr_idle_drop: busy=%0b, required 0", busy16); end

        for (int i = 0; i < N; i++) drive_sample(-30 + 7 * i);
        begin
            int guard = 0;
            int e;
            while (!out_valid16 && guard < 40) begin @(posedge clk); #1; guard++; end
            n_compared++;
            if (!out_valid16 || exp_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL clr_valid: out_valid=%0b queued=%0d, required 1 with a queued result", out_valid16, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                n_compared++;
                if (int'(out_data16) !== wrap16(e) || int'(out_data12) !== wrap12(e)) begin
                    n_mismatched++;
                    $display("[TB] FAIL clr_result: got %0d/%0d, required %0d/%0d", out_data16, out_data12, wrap16(e), wrap12(e));
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_acc = 0;
        model_idx = 0;
        for (int i = 0; i < N; i++) model_coef[i] = 0;

        test_reset();
        test_basic_frame();
        test_extremes();
        test_backpressure();
        test_config_lockout();
        test_clr();

        n_compared++;
        if (exp_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL leftover_results: queued=%0d, required 0", exp_q.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
